serial_subtractor: RTL

Bit-serial, LSB-first subtractor computing `a - b` over `WIDTH` clock cycles. It uses one full-subtractor cell, built from two half subtractors, and a registered borrow. The block is the counterpart of the team's combinational full-adder datapath: it trades area for latency wherever a wide parallel subtract is not justified. It sits behind a start/busy/done handshake, so control FSMs can launch an operation and poll for completion.

---
 rtl/serial_subtractor.sv | 121 ++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor (a - b) with a start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CW-1:0]    cnt;
    logic             br;

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic a_msb;
    logic b_msb;
`endif

    logic x, y;
    logic hs1_d, hs1_b, hs2_b;
    logic d, br_next;

    // Full subtractor built from two cascaded half subtractors.
    always_comb begin
        x       = a_reg[0];
        y       = b_reg[0];
        hs1_d   = x ^ y;
        hs1_b   = ~x & y;
        d       = hs1_d ^ br;
        hs2_b   = ~hs1_d & br;
        br_next = hs1_b | hs2_b;
    end

    assign borrow_out = br;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            diff  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            overflow <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= SHIFT;
                        a_reg <= a;
                        b_reg <= b;
                        cnt   <= '0;
                        br    <= 1'b0;
                        diff  <= '0;
                        busy  <= 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        a_msb    <= a[WIDTH-1];
                        b_msb    <= b[WIDTH-1];
                        overflow <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    diff  <= {d, diff[WIDTH-1:1]};
                    br    <= br_next;
                    a_reg <= a_reg >> 1;
                    b_reg <= b_reg >> 1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        // The final d is the result MSB landing this edge.
                        overflow <= (a_msb ^ b_msb) & (d ^ a_msb);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
